// File: rtl/r5_const_cmul.sv
// r5_const_cmul: pipelined complex-by-real-constant multiplier for the
// radix-5 butterfly. One of four Q2.16 constants is picked per sample, with
// an optional -j rotation. Three register stages with valid/ready flow control.
// Build option: define R5CMUL_CONVERGENT_EN for round-half-to-even; the
// default build rounds half toward +inf.
module r5_const_cmul #(
    parameter int W = 16,
    parameter logic signed [17:0] K0 = 18'sd20252,
    parameter logic signed [17:0] K1 = -18'sd53020,
    parameter logic signed [17:0] K2 = 18'sd62329,
    parameter logic signed [17:0] K3 = 18'sd38521
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] in_re,
    input  logic signed [W-1:0] in_im,
    input  logic [1:0]          in_sel,
    input  logic                in_rot,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] out_re,
    output logic signed [W-1:0] out_im,
    output logic                out_sat
);

    localparam int PW = W + 18;     // exact product width
    localparam int RW = W + 3;      // rounded width, room for negation and clamp

    localparam logic [PW:0]             HALF    = {{(PW-15){1'b0}}, 16'h8000};
    localparam logic signed [RW-1:0]    SAT_HI  = {4'b0000, {(W-1){1'b1}}};
    localparam logic signed [RW-1:0]    SAT_LO  = {4'b1111, {(W-1){1'b0}}};
`ifdef R5CMUL_CONVERGENT_EN
    localparam logic signed [RW-1:0]    ONE     = RW'(1);
`endif

    logic                  adv;
    logic                  s1_valid;
    logic signed [W-1:0]   s1_re;
    logic signed [W-1:0]   s1_im;
    logic [1:0]            s1_sel;
    logic                  s1_rot;
    logic signed [17:0]    k_sel;
    logic signed [PW-1:0]  a_re;
    logic signed [PW-1:0]  a_im;
    logic signed [PW-1:0]  k_ext;
    logic signed [PW-1:0]  p_re;
    logic signed [PW-1:0]  p_im;
    logic                  s2_valid;
    logic signed [PW-1:0]  s2_p_re;
    logic signed [PW-1:0]  s2_p_im;
    logic                  s2_rot;
    logic signed [RW-1:0]  r_re;
    logic signed [RW-1:0]  r_im;
    logic signed [RW-1:0]  neg_re;
    logic [W-1:0]          c_re;
    logic [W-1:0]          c_im;
    logic [W-1:0]          nxt_re;
    logic [W-1:0]          nxt_im;
    logic                  nxt_sat;

    // Round the Q2.16-scaled product back to integer scale.
    function automatic logic signed [RW-1:0] round_p(input logic signed [PW-1:0] p);
        logic [PW:0]          s;
        logic signed [RW-1:0] r;
        s = {p[PW-1], p} + HALF;
        r = s[PW:16];
`ifdef R5CMUL_CONVERGENT_EN
        // exact tie that rounded up onto an odd value: step back to the even one
        if (p[15:0] == 16'h8000 && s[16])
            r = r - ONE;
`endif
        return r;
    endfunction

    function automatic logic [W-1:0] sat_w(input logic signed [RW-1:0] r);
        if (r > SAT_HI)
            return SAT_HI[W-1:0];
        else if (r < SAT_LO)
            return SAT_LO[W-1:0];
        else
            return r[W-1:0];
    endfunction

    function automatic logic clamps(input logic signed [RW-1:0] r);
        return (r > SAT_HI) || (r < SAT_LO);
    endfunction

    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    // Stage 1: capture operands and per-sample controls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_re    <= '0;
            s1_im    <= '0;
            s1_sel   <= '0;
            s1_rot   <= 1'b0;
        end else if (adv) begin
            s1_valid <= in_valid;
            s1_re    <= in_re;
            s1_im    <= in_im;
            s1_sel   <= in_sel;
            s1_rot   <= in_rot;
        end
    end

    // Coefficient select and sign-extended full-precision products.
    always_comb begin
        k_sel = K0;
        case (s1_sel)
            2'd0: k_sel = K0;
            2'd1: k_sel = K1;
            2'd2: k_sel = K2;
            2'd3: k_sel = K3;
            default: k_sel = K0;
        endcase
        a_re  = {{18{s1_re[W-1]}}, s1_re};
        a_im  = {{18{s1_im[W-1]}}, s1_im};
        k_ext = {{W{k_sel[17]}}, k_sel};
        p_re  = a_re * k_ext;
        p_im  = a_im * k_ext;
    end

    // Stage 2: register the exact products.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_p_re  <= '0;
            s2_p_im  <= '0;
            s2_rot   <= 1'b0;
        end else if (adv) begin
            s2_valid <= s1_valid;
            s2_p_re  <= p_re;
            s2_p_im  <= p_im;
            s2_rot   <= s1_rot;
        end
    end

    // Round, clamp, then optionally rotate by -j; R_re is clamped before negation.
    always_comb begin
        r_re    = round_p(s2_p_re);
        r_im    = round_p(s2_p_im);
        c_re    = sat_w(r_re);
        c_im    = sat_w(r_im);
        neg_re  = -{{3{c_re[W-1]}}, c_re};
        nxt_re  = c_re;
        nxt_im  = c_im;
        nxt_sat = clamps(r_re) | clamps(r_im);
        if (s2_rot) begin
            nxt_re  = c_im;
            nxt_im  = sat_w(neg_re);
            nxt_sat = nxt_sat | clamps(neg_re);
        end
    end

    // Stage 3: output register, held while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
            out_sat   <= 1'b0;
        end else if (adv) begin
            out_valid <= s2_valid;
            out_re    <= nxt_re;
            out_im    <= nxt_im;
            out_sat   <= s2_valid & nxt_sat;
        end
    end

endmodule

// File: tb/tb_r5_const_cmul.sv
// Scoreboard bench for r5_const_cmul: three instances (default W=16,
// W=16 with K2/K3 overridden for clamp corners, W=24 for the rounding tie).
module tb_r5_const_cmul;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n;
    logic signed [23:0] in_re, in_im;
    logic [1:0]         in_sel;
    logic               in_rot;
    logic               out_ready;
    logic               vld_a, vld_b, vld_c;
    logic               rdy_a, rdy_b, rdy_c;
    logic               ov_a, ov_b, ov_c;
    logic               sat_a, sat_b, sat_c;
    logic signed [15:0] a_re, a_im, b_re, b_im;
    logic signed [23:0] c_re, c_im;

`ifdef R5CMUL_CONVERGENT_EN
    localparam int TIE_A_RE = -6628;
    localparam int TIE_C    = 19260;
`else
    localparam int TIE_A_RE = -6627;
    localparam int TIE_C    = 19261;
`endif

    r5_const_cmul #(.W(16)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(vld_a), .in_ready(rdy_a),
        .in_re(in_re[15:0]), .in_im(in_im[15:0]), .in_sel(in_sel), .in_rot(in_rot),
        .out_valid(ov_a), .out_ready(out_ready), .out_re(a_re), .out_im(a_im), .out_sat(sat_a));

    r5_const_cmul #(.W(16), .K2(-18'sd65536), .K3(18'sd131071)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(vld_b), .in_ready(rdy_b),
        .in_re(in_re[15:0]), .in_im(in_im[15:0]), .in_sel(in_sel), .in_rot(in_rot),
        .out_valid(ov_b), .out_ready(out_ready), .out_re(b_re), .out_im(b_im), .out_sat(sat_b));

    r5_const_cmul #(.W(24)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(vld_c), .in_ready(rdy_c),
        .in_re(in_re), .in_im(in_im), .in_sel(in_sel), .in_rot(in_rot),
        .out_valid(ov_c), .out_ready(out_ready), .out_re(c_re), .out_im(c_im), .out_sat(sat_c));

    typedef struct {
        int re;
        int im;
        bit sat;
        int id;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int qsize(input int d);
        case (d)
            0: return qa.size();
            1: return qb.size();
            default: return qc.size();
        endcase
    endfunction

    function automatic exp_t qhead(input int d);
        case (d)
            0: return qa[0];
            1: return qb[0];
            default: return qc[0];
        endcase
    endfunction

    task automatic qpush(input int d, input exp_t e);
        case (d)
            0: qa.push_back(e);
            1: qb.push_back(e);
            default: qc.push_back(e);
        endcase
    endtask

    task automatic qpop(input int d);
        case (d)
            0: void'(qa.pop_front());
            1: void'(qb.pop_front());
            default: void'(qc.pop_front());
        endcase
    endtask

    // Drive one sample into instance d; expectation is queued on acceptance.
    task automatic send(input int d, input int re, input int im, input int sel, input int rot,
                        input int ere, input int eim, input bit esat, input int id);
        exp_t e;
        bit   done;
        bit   rdy;
        e = '{ere, eim, esat, id};
        done = 1'b0;
        in_re  = re[23:0];
        in_im  = im[23:0];
        in_sel = sel[1:0];
        in_rot = rot[0];
        vld_a  = (d == 0);
        vld_b  = (d == 1);
        vld_c  = (d == 2);
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            rdy = (d == 0) ? rdy_a : (d == 1) ? rdy_b : rdy_c;
            if (rdy) begin
                qpush(d, e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            n_total++;
            $display("FAIL send_timeout: dut%0d sample %0d never accepted, expected acceptance", d, id);
        end
        vld_a = 1'b0;
        vld_b = 1'b0;
        vld_c = 1'b0;
    endtask

    // Compare whatever an instance presents against its scoreboard head.
    task automatic mon(input int d, input int are, input int aim, input bit asat,
                       input bit v, input bit rdy);
        exp_t e;
        if (v) begin
            if (qsize(d) == 0) begin
                n_total++;
                $display("FAIL dut%0d_unexpected_output: got (%0d,%0d), expected no output", d, are, aim);
            end else begin
                e = qhead(d);
                chk($sformatf("dut%0d_re#%0d", d, e.id), are, e.re);
                chk($sformatf("dut%0d_im#%0d", d, e.id), aim, e.im);
                chk($sformatf("dut%0d_sat#%0d", d, e.id), int'(asat), int'(e.sat));
                if (out_ready) qpop(d);
            end
            if (!out_ready)
                chk($sformatf("dut%0d_in_ready_stalled", d), int'(rdy), 0);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon(0, int'(a_re), int'(a_im), sat_a, ov_a, rdy_a);
            mon(1, int'(b_re), int'(b_im), sat_b, ov_b, rdy_b);
            mon(2, int'(c_re), int'(c_im), sat_c, ov_c, rdy_c);
        end
    end

    task automatic drain();
        for (int n = 0; n < 300 && (qa.size() + qb.size() + qc.size()) != 0; n++) begin
            @(posedge clk);
            #1;
        end
        if ((qa.size() + qb.size() + qc.size()) != 0) begin
            n_total++;
            $display("FAIL drain_timeout: %0d/%0d/%0d outputs outstanding, expected 0",
                     qa.size(), qb.size(), qc.size());
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_out_valid"}, int'(ov_a), 0);
        chk({tag, "_out_re"},    int'(a_re), 0);
        chk({tag, "_out_im"},    int'(a_im), 0);
        chk({tag, "_out_sat"},   int'(sat_a), 0);
        chk({tag, "_in_ready"},  int'(rdy_a), 1);
    endtask

    initial begin
        int lat;
        rst_n = 1'b0;
        in_re = '0; in_im = '0; in_sel = '0; in_rot = 1'b0;
        vld_a = 1'b0; vld_b = 1'b0; vld_c = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_idle("reset");

        // latency: input cycle to out_valid cycle
        send(0, 16384, 0, 0, 0, 5063, 0, 1'b0, 1);
        lat = 1;
        for (int n = 0; n < 10 && !ov_a; n++) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", lat, 3);
        drain();

        // coefficient sweep, rotation, rounding tie on K1
        send(0, 16384, -16384, 1, 0, -13255, 13255, 1'b0, 2);
        send(0, 16384, 0, 2, 1, 0, -15582, 1'b0, 3);
        send(0, 8192, -8192, 1, 0, TIE_A_RE, 6628, 1'b0, 4);
        drain();

        // backpressure: six back-to-back samples, out_ready low in cycles 4..7
        fork
            begin
                send(0, 1000, -1000, 0, 0, 309, -309, 1'b0, 10);
                send(0, -2000, 3000, 1, 0, 1618, -2427, 1'b0, 11);
                send(0, 32767, 32767, 2, 0, 31164, 31164, 1'b0, 12);
                send(0, -32768, 12345, 3, 1, 7256, 19260, 1'b0, 13);
                send(0, 100, -100, 1, 1, 81, 81, 1'b0, 14);
                send(0, -1, -1, 0, 0, 0, 0, 1'b0, 15);
            end
            begin
                for (int c = 1; c <= 12; c++) begin
                    out_ready = !(c >= 4 && c <= 7);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // asynchronous reset with samples in flight
        send(0, 1000, -1000, 0, 0, 309, -309, 1'b0, 20);
        send(0, -2000, 3000, 1, 0, 1618, -2427, 1'b0, 21);
        @(posedge clk);
        #1;
        chk("pre_reset_out_valid", int'(ov_a), 1);
        rst_n = 1'b0;
        #1;
        chk_idle("midreset");
        qa.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("post_reset_no_output", int'(ov_a), 0);

        // clamp corners with overridden K2/K3
        send(1, 32767, -32768, 3, 0, 32767, -32768, 1'b1, 30);
        send(1, -32768, 0, 2, 1, 0, -32767, 1'b1, 31);
        send(1, -16384, 0, 3, 1, 0, 32767, 1'b1, 32);
        send(1, 100, 0, 2, 0, -100, 0, 1'b0, 33);

        // W=24 exact tie on K3
        send(2, 32768, 0, 3, 0, TIE_C, 0, 1'b0, 40);
        send(2, 0, 32768, 3, 1, TIE_C, 0, 1'b0, 41);
        drain();

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
